// File: rtl/imm_gen_pipe_if.sv
// Decode-to-execute immediate channel: request side (instruction, format) and
// FIFO head side (immediate, error flag, occupancy).
interface imm_gen_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [24:0]           instruction;
  logic [2:0]            imm_fmt;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] imm_data;
  logic                  imm_err;
  logic [CW-1:0]         count;

  modport master (
    output flush, in_valid, instruction, imm_fmt, out_ready,
    input  in_ready, out_valid, imm_data, imm_err, count
  );

  modport slave (
    input  flush, in_valid, instruction, imm_fmt, out_ready,
    output in_ready, out_valid, imm_data, imm_err, count
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV32/RV64 immediate extractor feeding a DEPTH-entry circular output FIFO.
// Decode is combinational on push; the FIFO head drives the outputs directly.
module imm_gen_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  imm_gen_pipe_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef struct packed {
    logic  err;
    data_t imm;
  } entry_t;

  localparam logic [2:0] F_I = 3'd0, F_S = 3'd1, F_B = 3'd2, F_U = 3'd3,
                         F_J = 3'd4, F_SH = 3'd5, F_Z = 3'd6;

  logic [24:0] w_in;
  entry_t      w_dec;
  logic        w_push, w_pop;

  entry_t      r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;

  assign w_in = bus.instruction;

  // Size casts of signed concatenations perform the sign extension.
  always_comb begin
    w_dec = '0;
    case (bus.imm_fmt)
      F_I:  w_dec.imm = data_t'($signed(w_in[24:13]));
      F_S:  w_dec.imm = data_t'($signed({w_in[24:18], w_in[4:0]}));
      F_B:  w_dec.imm = data_t'($signed({w_in[24], w_in[0], w_in[23:18], w_in[4:1], 1'b0}));
      F_U:  w_dec.imm = data_t'($signed({w_in[24:5], 12'h000}));
      F_J:  w_dec.imm = data_t'($signed({w_in[24], w_in[12:5], w_in[13], w_in[23:14], 1'b0}));
      F_SH: w_dec.imm = (DATA_WIDTH == 64) ? data_t'(w_in[18:13]) : data_t'(w_in[17:13]);
      F_Z:  w_dec.imm = data_t'(w_in[12:8]);
      default: w_dec.err = 1'b1;
    endcase
  end

  // in_ready depends only on the occupancy register, never on out_ready.
  assign bus.in_ready  = (r_count != CW'(DEPTH));
  assign bus.out_valid = (r_count != '0);
  assign w_push = bus.in_valid && bus.in_ready && !bus.flush;
  assign w_pop  = bus.out_valid && bus.out_ready && !bus.flush;

  assign bus.imm_data = bus.out_valid ? r_mem[r_rptr].imm : '0;
  assign bus.imm_err  = bus.out_valid ? r_mem[r_rptr].err : 1'b0;
  assign bus.count    = r_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
